// File: rtl/sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
// Shared definitions for the SRAM port arbiter:
//   - arb_state_e : arbiter FSM encoding (IDLE, IF_HI)
//   - req_id_t    : requester tag carried down the read-return pipeline
//                   (ID_NONE, ID_IO, ID_DM, ID_IF)
//   - GNT_*       : bit positions inside the one-hot grant vector
//   - RR_*        : round-robin pointer values (which of DM/IF is favoured)
//   - DEF_*       : default SRAM geometry (RA1SHD 1024x8)
// Optional feature macro used by the arbiter files: SRAM_ARB_RR_EN
// ---------------------------------------------------------------------------
package sram_arb_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 10;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    IF_HI = 1'b1
  } arb_state_e;

  typedef logic [1:0] req_id_t;

  localparam req_id_t ID_NONE = 2'd0;
  localparam req_id_t ID_IO   = 2'd1;
  localparam req_id_t ID_DM   = 2'd2;
  localparam req_id_t ID_IF   = 2'd3;

  localparam int GNT_IO = 0;
  localparam int GNT_DM = 1;
  localparam int GNT_IF = 2;

  localparam logic RR_DM = 1'b0;
  localparam logic RR_IF = 1'b1;

endpackage

// File: rtl/sram_arb_sel.sv
// ---------------------------------------------------------------------------
// sram_arb_sel
// Combinational grant selector for the SRAM port arbiter.
// IO always has absolute priority. Between DM and IF:
//   SRAM_ARB_RR_EN defined   : round-robin, rr_ptr names the favoured port
//   SRAM_ARB_RR_EN undefined : fixed priority DM > IF, rr_ptr ignored
// Ports:
//   io_req, dm_req, if_req : requests from the three ports
//   rr_ptr                 : round-robin pointer (RR_DM / RR_IF)
//   gnt                    : one-hot grant, bit positions GNT_IO/GNT_DM/GNT_IF
// ---------------------------------------------------------------------------
module sram_arb_sel
  import sram_arb_pkg::*;
(
  input  logic       io_req,
  input  logic       dm_req,
  input  logic       if_req,
  input  logic       rr_ptr,
  output logic [2:0] gnt
);

`ifndef SRAM_ARB_RR_EN
  // Fixed-priority build has no use for the pointer.
  logic unused_rr_ptr_s;
  assign unused_rr_ptr_s = rr_ptr;
`endif

  // Pick exactly one requester (or none) for this cycle.
  always_comb begin
    gnt = 3'b000;
    if (io_req) begin
      gnt[GNT_IO] = 1'b1;
    end
`ifdef SRAM_ARB_RR_EN
    else if (dm_req && if_req) begin
      // Contention: the port not served last is the favoured one.
      if (rr_ptr == RR_DM) begin
        gnt[GNT_DM] = 1'b1;
      end else begin
        gnt[GNT_IF] = 1'b1;
      end
    end
`endif
    else if (dm_req) begin
      gnt[GNT_DM] = 1'b1;
    end else if (if_req) begin
      gnt[GNT_IF] = 1'b1;
    end else begin
      gnt = 3'b000;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
// Shares one single-port 1024x8 SRAM between the serial IO controller (IO),
// the CPU data port (DM, byte access) and the CPU instruction-fetch port
// (IF, 16-bit word fetched as two byte reads, low byte at the even address).
// Optional feature macro: SRAM_ARB_RR_EN (round-robin DM/IF arbitration).
// Ports:
//   CLK, RST                 : clock, synchronous active-high reset
//   IO_REQ/WE/A/D            : IO request, held until IO_GNT
//   IO_GNT/VLD/Q             : grant pulse, read-valid pulse, registered data
//   DM_*                     : same set for the CPU data port
//   IF_REQ/IF_A              : fetch request, word address
//   IF_GNT/IF_VLD/IF_Q       : grant at low-byte issue, valid pulse, word
//   CEN/WEN/A/D              : SRAM control/address/write data (issue cycle)
//   Q                        : SRAM read data, valid the cycle after issue
// Timing: GNT/CEN/WEN/A/D are combinational in the issue cycle d; byte reads
// return VLD/Q in d+2, fetches return IF_VLD/IF_Q in d+3.
// ---------------------------------------------------------------------------
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter  int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  localparam int INSTR_WIDTH = 2 * DATA_WIDTH
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   IO_REQ,
  input  logic                   IO_WE,
  input  logic [ADDR_WIDTH-1:0]  IO_A,
  input  logic [DATA_WIDTH-1:0]  IO_D,
  output logic                   IO_GNT,
  output logic                   IO_VLD,
  output logic [DATA_WIDTH-1:0]  IO_Q,
  input  logic                   DM_REQ,
  input  logic                   DM_WE,
  input  logic [ADDR_WIDTH-1:0]  DM_A,
  input  logic [DATA_WIDTH-1:0]  DM_D,
  output logic                   DM_GNT,
  output logic                   DM_VLD,
  output logic [DATA_WIDTH-1:0]  DM_Q,
  input  logic                   IF_REQ,
  input  logic [ADDR_WIDTH-2:0]  IF_A,
  output logic                   IF_GNT,
  output logic                   IF_VLD,
  output logic [INSTR_WIDTH-1:0] IF_Q,
  output logic                   CEN,
  output logic                   WEN,
  output logic [ADDR_WIDTH-1:0]  A,
  output logic [DATA_WIDTH-1:0]  D,
  input  logic [DATA_WIDTH-1:0]  Q
);

  arb_state_e              state_q, state_d;
  logic [ADDR_WIDTH-2:0]   if_a_q, if_a_d;
  logic [ADDR_WIDTH-1:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0]   wd_q, wd_d;
  req_id_t                 pend_id_q, pend_id_d;
  logic                    pend_hi_q, pend_hi_d;
  logic [DATA_WIDTH-1:0]   io_q_q, io_q_d;
  logic [DATA_WIDTH-1:0]   dm_q_q, dm_q_d;
  logic [INSTR_WIDTH-1:0]  if_q_q, if_q_d;
  logic                    io_vld_q, io_vld_d;
  logic                    dm_vld_q, dm_vld_d;
  logic                    if_vld_q, if_vld_d;

  logic                    cen_s, wen_s;
  logic                    io_gnt_s, dm_gnt_s, if_gnt_s;
  logic [2:0]              sel_gnt_s;
  logic                    rr_ptr_s;

  sram_arb_sel u_sel (
    .io_req (IO_REQ),
    .dm_req (DM_REQ),
    .if_req (IF_REQ),
    .rr_ptr (rr_ptr_s),
    .gnt    (sel_gnt_s)
  );

`ifdef SRAM_ARB_RR_EN
  logic rr_q, rr_d;

  // Round-robin pointer register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_q <= RR_DM;
    end else begin
      rr_q <= rr_d;
    end
  end

  // Favour the other port after every DM or IF grant; IO leaves it alone.
  always_comb begin
    rr_d = rr_q;
    if (!RST && (state_q == IDLE) && sel_gnt_s[GNT_DM]) begin
      rr_d = RR_IF;
    end else if (!RST && (state_q == IDLE) && sel_gnt_s[GNT_IF]) begin
      rr_d = RR_DM;
    end else begin
      rr_d = rr_q;
    end
  end

  assign rr_ptr_s = rr_q;
`else
  assign rr_ptr_s = RR_DM;
`endif

  // FSM next state, SRAM issue mux and read-return capture.
  always_comb begin
    state_d   = state_q;
    if_a_d    = if_a_q;
    a_d       = a_q;
    wd_d      = wd_q;
    pend_id_d = ID_NONE;
    pend_hi_d = 1'b0;
    io_q_d    = io_q_q;
    dm_q_d    = dm_q_q;
    if_q_d    = if_q_q;
    io_vld_d  = 1'b0;
    dm_vld_d  = 1'b0;
    if_vld_d  = 1'b0;
    cen_s     = 1'b1;
    wen_s     = 1'b1;
    io_gnt_s  = 1'b0;
    dm_gnt_s  = 1'b0;
    if_gnt_s  = 1'b0;

    if (RST) begin
      // Nothing issues and nothing in flight survives; the SRAM pins show
      // their reset values straight away.
      state_d = IDLE;
      if_a_d  = {(ADDR_WIDTH-1){1'b0}};
      a_d     = {ADDR_WIDTH{1'b0}};
      wd_d    = {DATA_WIDTH{1'b0}};
      io_q_d  = {DATA_WIDTH{1'b0}};
      dm_q_d  = {DATA_WIDTH{1'b0}};
      if_q_d  = {INSTR_WIDTH{1'b0}};
    end else begin
      // SRAM Q belongs to whatever read was issued last cycle.
      case (pend_id_q)
        ID_IO: begin
          io_q_d   = Q;
          io_vld_d = 1'b1;
        end
        ID_DM: begin
          dm_q_d   = Q;
          dm_vld_d = 1'b1;
        end
        ID_IF: begin
          if (pend_hi_q) begin
            if_q_d[INSTR_WIDTH-1:DATA_WIDTH] = Q;
            if_vld_d                         = 1'b1;
          end else begin
            if_q_d[DATA_WIDTH-1:0] = Q;
          end
        end
        default: begin
          pend_id_d = ID_NONE;
        end
      endcase

      case (state_q)
        IDLE: begin
          if (sel_gnt_s[GNT_IO]) begin
            io_gnt_s = 1'b1;
            cen_s    = 1'b0;
            wen_s    = ~IO_WE;
            a_d      = IO_A;
            if (IO_WE) begin
              wd_d = IO_D;
            end else begin
              pend_id_d = ID_IO;
            end
          end else if (sel_gnt_s[GNT_DM]) begin
            dm_gnt_s = 1'b1;
            cen_s    = 1'b0;
            wen_s    = ~DM_WE;
            a_d      = DM_A;
            if (DM_WE) begin
              wd_d = DM_D;
            end else begin
              pend_id_d = ID_DM;
            end
          end else if (sel_gnt_s[GNT_IF]) begin
            // Low byte now; the high byte is forced next cycle so the word
            // read cannot be split by another requester.
            if_gnt_s  = 1'b1;
            cen_s     = 1'b0;
            a_d       = {IF_A, 1'b0};
            if_a_d    = IF_A;
            pend_id_d = ID_IF;
            state_d   = IF_HI;
          end else begin
            state_d = IDLE;
          end
        end
        IF_HI: begin
          cen_s     = 1'b0;
          a_d       = {if_a_q, 1'b1};
          pend_id_d = ID_IF;
          pend_hi_d = 1'b1;
          state_d   = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, hold and return-pipeline registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      if_a_q    <= {(ADDR_WIDTH-1){1'b0}};
      a_q       <= {ADDR_WIDTH{1'b0}};
      wd_q      <= {DATA_WIDTH{1'b0}};
      pend_id_q <= ID_NONE;
      pend_hi_q <= 1'b0;
      io_q_q    <= {DATA_WIDTH{1'b0}};
      dm_q_q    <= {DATA_WIDTH{1'b0}};
      if_q_q    <= {INSTR_WIDTH{1'b0}};
      io_vld_q  <= 1'b0;
      dm_vld_q  <= 1'b0;
      if_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      if_a_q    <= if_a_d;
      a_q       <= a_d;
      wd_q      <= wd_d;
      pend_id_q <= pend_id_d;
      pend_hi_q <= pend_hi_d;
      io_q_q    <= io_q_d;
      dm_q_q    <= dm_q_d;
      if_q_q    <= if_q_d;
      io_vld_q  <= io_vld_d;
      dm_vld_q  <= dm_vld_d;
      if_vld_q  <= if_vld_d;
    end
  end

  assign CEN    = cen_s;
  assign WEN    = wen_s;
  assign A      = a_d;
  assign D      = wd_d;
  assign IO_GNT = io_gnt_s;
  assign DM_GNT = dm_gnt_s;
  assign IF_GNT = if_gnt_s;
  assign IO_VLD = io_vld_q;
  assign DM_VLD = dm_vld_q;
  assign IF_VLD = if_vld_q;
  assign IO_Q   = io_q_q;
  assign DM_Q   = dm_q_q;
  assign IF_Q   = if_q_q;

endmodule
